// File: rtl/qam64_bit_packer_if.sv
// Bit-stream input and packed-symbol output bundle of the QAM-64 bit packer.
// The master drives bits and symbol acceptance; the slave is the packer itself.
interface qam64_bit_packer_if #(
   parameter int SYM_BITS   = 6,
   parameter int FIFO_DEPTH = 4
);
   logic                          bit_in;
   logic                          bit_valid;
   logic                          bit_last;
   logic                          bit_ready;
   logic [SYM_BITS-1:0]           sym_out;
   logic                          sym_valid;
   logic                          sym_last;
   logic [$clog2(SYM_BITS)-1:0]   sym_pad;
   logic                          sym_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   modport master (
      output bit_in, bit_valid, bit_last, sym_ready,
      input  bit_ready, sym_out, sym_valid, sym_last, sym_pad, fifo_level
   );

   modport slave (
      input  bit_in, bit_valid, bit_last, sym_ready,
      output bit_ready, sym_out, sym_valid, sym_last, sym_pad, fifo_level
   );
endinterface

// File: rtl/qam64_bit_packer.sv
// Packs a serial bit stream MSB-first into SYM_BITS-wide symbols, zero-padding a short final symbol.
// A symbol appears one cycle after its final bit; bit_ready drops while the symbol FIFO is full.
module qam64_bit_packer #(
   parameter int SYM_BITS   = 6,
   parameter int FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   qam64_bit_packer_if.slave bus
);
   localparam int CW = $clog2(SYM_BITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [SYM_BITS-1:0] shreg;
   logic [SYM_BITS-1:0] sym_asm;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       pad;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [LW-1:0]       level;
   logic                accept;
   logic                push;
   logic                pop;

   logic [SYM_BITS-1:0] mem_sym  [FIFO_DEPTH];
   logic                mem_last [FIFO_DEPTH];
   logic [CW-1:0]       mem_pad  [FIFO_DEPTH];

   // Last popped entry, shown while the FIFO is empty.
   logic [SYM_BITS-1:0] hold_sym;
   logic                hold_last;
   logic [CW-1:0]       hold_pad;

   assign bus.bit_ready  = (level != LW'(FIFO_DEPTH)) && !rst;
   assign bus.sym_valid  = (level != '0);
   assign bus.fifo_level = level;
   assign bus.sym_out    = bus.sym_valid ? mem_sym[rd_ptr]  : hold_sym;
   assign bus.sym_last   = bus.sym_valid ? mem_last[rd_ptr] : hold_last;
   assign bus.sym_pad    = bus.sym_valid ? mem_pad[rd_ptr]  : hold_pad;

   assign accept = bus.bit_valid && bus.bit_ready;
   assign push   = accept && ((cnt == CW'(SYM_BITS-1)) || bus.bit_last);
   assign pop    = bus.sym_valid && bus.sym_ready;
   // Unwritten LSBs are already zero because the shift register clears on every push.
   assign pad    = CW'(SYM_BITS-1) - cnt;

   always_comb begin
      sym_asm = shreg;
      for (int i = 0; i < SYM_BITS; i++) begin
         if (CW'(SYM_BITS-1-i) == cnt) begin
            sym_asm[i] = bus.bit_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         hold_sym  <= '0;
         hold_last <= 1'b0;
         hold_pad  <= '0;
      end else begin
         if (push) begin
            shreg  <= '0;
            cnt    <= '0;
            wr_ptr <= wr_ptr + 1'b1;
         end else if (accept) begin
            shreg <= sym_asm;
            cnt   <= cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            hold_sym  <= mem_sym[rd_ptr];
            hold_last <= mem_last[rd_ptr];
            hold_pad  <= mem_pad[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_sym[wr_ptr]  <= sym_asm;
         mem_last[wr_ptr] <= bus.bit_last;
         mem_pad[wr_ptr]  <= pad;
      end
   end
endmodule

// File: tb/tb_qam64_bit_packer.sv
// Directed and randomized checks of the QAM-64 bit packer against hand-computed symbols and a scoreboard.
module tb_qam64_bit_packer;
   localparam int SB = 6;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qam64_bit_packer_if #(.SYM_BITS(SB), .FIFO_DEPTH(FD)) bus ();
   qam64_bit_packer #(.SYM_BITS(SB), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   logic [5:0] got_sym  [$];
   logic       got_last [$];
   logic [2:0] got_pad  [$];

   always @(negedge clk) begin
      if (!rst && bus.sym_valid && bus.sym_ready) begin
         got_sym.push_back(bus.sym_out);
         got_last.push_back(bus.sym_last);
         got_pad.push_back(bus.sym_pad);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_got();
      got_sym.delete();
      got_last.delete();
      got_pad.delete();
   endtask

   task automatic send_bit(input logic b, input logic l);
      int n = 0;
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      bus.bit_last  = l;
      @(negedge clk);
      while (!bus.bit_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!bus.bit_ready) begin
         checks++;
         failures++;
         $display("FAIL send_bit_timeout bit_ready=%0b required=1", bus.bit_ready);
      end
      @(posedge clk);
      #1;
      bus.bit_valid = 1'b0;
      bus.bit_last  = 1'b0;
   endtask

   // Sends the first n bits of s, MSB first; bit_last on the final one if l is set.
   task automatic send_sym(input logic [5:0] s, input int n, input logic l);
      for (int i = 0; i < n; i++) begin
         send_bit(s[5-i], l && (i == n-1));
      end
   endtask

   task automatic drain();
      int n = 0;
      bus.sym_ready = 1'b1;
      while (bus.sym_valid && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (bus.sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout sym_valid=%0b required=0", bus.sym_valid);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_last  = 1'b0;
      bus.sym_ready = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.sym_valid, bus.sym_last, bus.sym_pad, bus.sym_out, bus.fifo_level, bus.bit_ready} !== '0) begin
         failures++;
         $display("FAIL reset_outputs valid=%0b last=%0b pad=%0d out=%b level=%0d ready=%0b required all 0",
                  bus.sym_valid, bus.sym_last, bus.sym_pad, bus.sym_out, bus.fifo_level, bus.bit_ready);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.bit_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%0b required=1", bus.bit_ready);
      end
   endtask

   task automatic test_full_symbols();
      bus.sym_ready = 1'b1;
      clear_got();
      send_sym(6'b000110, 5, 1'b0);
      checks++;
      if (bus.sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_early_valid got=%0b required=0", bus.sym_valid);
      end
      send_bit(1'b0, 1'b0);
      checks++;
      if ({bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad} !== {1'b1, 6'b000110, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL full_sym0 valid=%0b out=%b last=%0b pad=%0d required valid=1 out=000110 last=0 pad=0",
                  bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad);
      end
      send_sym(6'b111001, 6, 1'b0);
      checks++;
      if ({bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad} !== {1'b1, 6'b111001, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL full_sym1 valid=%0b out=%b last=%0b pad=%0d required valid=1 out=111001 last=0 pad=0",
                  bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad);
      end
      tick();
      checks++;
      if ({bus.sym_valid, bus.sym_out, bus.fifo_level} !== {1'b0, 6'b111001, 3'd0}) begin
         failures++;
         $display("FAIL empty_hold valid=%0b out=%b level=%0d required valid=0 out=111001 level=0",
                  bus.sym_valid, bus.sym_out, bus.fifo_level);
      end
      checks++;
      if (got_sym.size() != 2 || got_sym[0] !== 6'b000110 || got_sym[1] !== 6'b111001) begin
         failures++;
         $display("FAIL full_order count=%0d required 2 symbols 000110,111001", got_sym.size());
      end
   endtask

   task automatic test_early_last();
      bus.sym_ready = 1'b1;
      send_sym(6'b101100, 4, 1'b1);
      checks++;
      if ({bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad} !== {1'b1, 6'b101100, 1'b1, 3'd2}) begin
         failures++;
         $display("FAIL early_last valid=%0b out=%b last=%0b pad=%0d required valid=1 out=101100 last=1 pad=2",
                  bus.sym_valid, bus.sym_out, bus.sym_last, bus.sym_pad);
      end
      tick();
      checks++;
      if (bus.sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL early_last_pop valid=%0b required=0", bus.sym_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] syms [5];
      syms[0] = 6'b101010;
      syms[1] = 6'b110011;
      syms[2] = 6'b000111;
      syms[3] = 6'b111000;
      syms[4] = 6'b011110;
      bus.sym_ready = 1'b0;
      clear_got();
      for (int k = 0; k < 4; k++) send_sym(syms[k], 6, 1'b0);
      checks++;
      if ({bus.fifo_level, bus.bit_ready} !== {3'd4, 1'b0}) begin
         failures++;
         $display("FAIL full_level level=%0d ready=%0b required level=4 ready=0", bus.fifo_level, bus.bit_ready);
      end
      fork
         send_sym(syms[4], 6, 1'b0);
         begin
            repeat (3) tick();
            checks++;
            if ({bus.fifo_level, bus.bit_ready} !== {3'd4, 1'b0}) begin
               failures++;
               $display("FAIL full_stall level=%0d ready=%0b required level=4 ready=0", bus.fifo_level, bus.bit_ready);
            end
            bus.sym_ready = 1'b1;
            tick();
            checks++;
            if ({bus.fifo_level, bus.bit_ready} !== {3'd3, 1'b1}) begin
               failures++;
               $display("FAIL full_release level=%0d ready=%0b required level=3 ready=1", bus.fifo_level, bus.bit_ready);
            end
         end
      join
      drain();
      checks++;
      if (got_sym.size() != 5) begin
         failures++;
         $display("FAIL bp_count got=%0d required=5", got_sym.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if ({got_sym[k], got_last[k], got_pad[k]} !== {syms[k], 1'b0, 3'd0}) begin
               failures++;
               $display("FAIL bp_sym%0d got=%b last=%0b pad=%0d required=%b last=0 pad=0",
                        k, got_sym[k], got_last[k], got_pad[k], syms[k]);
            end
         end
      end
   endtask

   task automatic test_push_pop_same_cycle();
      bus.sym_ready = 1'b0;
      clear_got();
      send_sym(6'b010101, 6, 1'b0);
      send_sym(6'b100001, 6, 1'b0);
      send_sym(6'b001011, 5, 1'b0);
      checks++;
      if (bus.fifo_level !== 3'd2) begin
         failures++;
         $display("FAIL pp_level_before got=%0d required=2", bus.fifo_level);
      end
      bus.sym_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      bus.sym_ready = 1'b0;
      checks++;
      if ({bus.fifo_level, bus.sym_out} !== {3'd2, 6'b100001}) begin
         failures++;
         $display("FAIL pp_level_after level=%0d head=%b required level=2 head=100001", bus.fifo_level, bus.sym_out);
      end
      drain();
      checks++;
      if (got_sym.size() != 3 || got_sym[0] !== 6'b010101 || got_sym[1] !== 6'b100001 || got_sym[2] !== 6'b001011) begin
         failures++;
         $display("FAIL pp_order count=%0d required 3 symbols 010101,100001,001011", got_sym.size());
      end
   endtask

   task automatic test_reset_midframe();
      bus.sym_ready = 1'b0;
      send_sym(6'b110011, 6, 1'b0);
      send_sym(6'b111000, 3, 1'b0);
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.sym_valid, bus.sym_last, bus.sym_pad, bus.sym_out, bus.fifo_level, bus.bit_ready} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs valid=%0b last=%0b pad=%0d out=%b level=%0d ready=%0b required all 0",
                  bus.sym_valid, bus.sym_last, bus.sym_pad, bus.sym_out, bus.fifo_level, bus.bit_ready);
      end
      tick();
      rst = 1'b0;
      bus.sym_ready = 1'b1;
      clear_got();
      send_sym(6'b100100, 6, 1'b0);
      checks++;
      if ({bus.sym_valid, bus.sym_out} !== {1'b1, 6'b100100}) begin
         failures++;
         $display("FAIL midreset_sym valid=%0b out=%b required valid=1 out=100100", bus.sym_valid, bus.sym_out);
      end
      drain();
      checks++;
      if (got_sym.size() != 1 || got_sym[0] !== 6'b100100 || got_last[0] !== 1'b0 || got_pad[0] !== 3'd0) begin
         failures++;
         $display("FAIL midreset_count count=%0d required exactly one symbol 100100", got_sym.size());
      end
   endtask

   task automatic test_random();
      logic [5:0] exp_sym  [$];
      logic       exp_last [$];
      logic [2:0] exp_pad  [$];
      logic [5:0] ms = '0;
      int         mn = 0;
      logic       done = 1'b0;
      logic       b, l;
      clear_got();
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  bus.bit_valid = 1'b0;
                  repeat ($urandom_range(1, 3)) tick();
               end
               b = 1'($urandom_range(0, 1));
               l = ($urandom_range(0, 15) == 0) || (i == 999);
               send_bit(b, l);
               ms[5-mn] = b;
               mn++;
               if (mn == 6 || l) begin
                  exp_sym.push_back(ms);
                  exp_last.push_back(l);
                  exp_pad.push_back(3'(6 - mn));
                  ms = '0;
                  mn = 0;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.sym_ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      drain();
      checks++;
      if (got_sym.size() != exp_sym.size()) begin
         failures++;
         $display("FAIL rand_count got=%0d required=%0d", got_sym.size(), exp_sym.size());
      end else begin
         for (int k = 0; k < exp_sym.size(); k++) begin
            checks++;
            if ({got_sym[k], got_last[k], got_pad[k]} !== {exp_sym[k], exp_last[k], exp_pad[k]}) begin
               failures++;
               $display("FAIL rand_sym%0d got=%b/%0b/%0d required=%b/%0b/%0d", k,
                        got_sym[k], got_last[k], got_pad[k], exp_sym[k], exp_last[k], exp_pad[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_symbols();
      test_early_last();
      test_backpressure();
      test_push_pop_same_cycle();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/qam64_bit_packer.md
Name: qam64_bit_packer

Overview:
- Upstream stage of the QAM-64 mapper chain.
- Accepts a serial bit stream through a valid/ready handshake and packs each group of SYM_BITS bits, MSB-first, into one symbol word.
- Buffers the packed symbols in a small FIFO and presents them to the real/imag mapper lookups through a valid/ready handshake.
- Handles frame ends: a partial final symbol is zero-padded, flagged as last, and reports how many bits were padded.

Parameters:
- SYM_BITS, 6, bits per symbol. 6 gives QAM-64, so the output feeds the 6-bit mapper input directly.
- FIFO_DEPTH, 4, symbol FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_last  in  1  this bit is the final bit of the frame; qualified by bit_valid.
- bit_ready  out  1  block can accept a bit this cycle.
- sym_out  out  SYM_BITS  packed symbol at the FIFO head; bit SYM_BITS-1 is the first bit received.
- sym_valid  out  1  sym_out is valid.
- sym_last  out  1  head symbol ends a frame.
- sym_pad  out  $clog2(SYM_BITS)  number of zero-padded LSBs in the head symbol; 0 for full symbols.
- sym_ready  in  1  downstream accepts the head symbol.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (synchronous, takes effect on the clk edge where rst=1):
  - shift register, bit counter, FIFO pointers and FIFO level all go to 0.
  - sym_valid=0, sym_last=0, sym_pad=0, sym_out=0, fifo_level=0.
  - A partially collected symbol is discarded. Reset mid-frame drops all buffered data.
- Handshakes:
  - A bit is accepted when bit_valid && bit_ready.
  - A symbol is popped when sym_valid && sym_ready.
- bit_ready = (fifo_level != FIFO_DEPTH) && !rst. It is based on the registered level only; a same-cycle pop does not raise bit_ready.
- Bit counter cnt runs 0..SYM_BITS-1. On each accepted bit:
  - the bit is written to position SYM_BITS-1-cnt of the shift register;
  - cnt increments.
- Push conditions, on an accepted bit:
  - Full symbol: cnt == SYM_BITS-1. Push {assembled symbol, last=bit_last, pad=0}; cnt returns to 0.
  - Early last: bit_last=1 with cnt < SYM_BITS-1. Push the symbol with its remaining LSBs forced to 0, last=1, pad = SYM_BITS-1-cnt; cnt returns to 0.
- The shift register is cleared after every push, so stale bits never leak into padding.
- Latency: a pushed symbol appears on sym_out/sym_valid in the cycle after its final bit is accepted. This holds when the FIFO was empty.
- Outputs are driven from registered FIFO storage and the read pointer. There is no combinational path from bit_* to sym_*.
- FIFO behaviour:
  - Simultaneous push and pop: level is unchanged and both operations occur. This is legal at any level below FIFO_DEPTH.
  - Full: no push can occur, because bit_ready=0. A pop makes bit_ready=1 on the next cycle.
  - Empty: sym_valid=0. sym_out, sym_last and sym_pad hold the last popped values, and downstream must ignore them.
  - Pointers wrap modulo FIFO_DEPTH.
- Source side:
  - bit_last with bit_valid=0 is ignored.
  - A frame of length 0 cannot be expressed.
  - Consecutive frames pack independently; the new frame starts at cnt=0.
- Symbol ordering: symbols are output strictly in push order.

Test Plan:
- After reset, send 12 bits 000110 111001 with sym_ready=1 -> sym_out=6'b000110 then 6'b111001. Both have sym_pad=0 and sym_last=0, and each appears one cycle after its 6th bit.
- Send 4 bits 1011 with bit_last on the 4th bit -> sym_out=6'b101100, sym_last=1, sym_pad=2.
- Hold sym_ready=0 and stream 30 bits -> 4 symbols buffered, fifo_level=4, bit_ready=0 after the 24th bit; the remaining bits stall. Release sym_ready -> all 5 symbols are output in order, with no loss or duplication.
- At fifo_level=2, complete a symbol in the same cycle as a pop -> fifo_level stays 2 and the ordering is preserved.
- Assert rst after 3 bits, then send 6 bits 100100 -> exactly one symbol 6'b100100; the 3 pre-reset bits are gone and all outputs were 0 during reset.
- Random bit_valid/sym_ready gaps over 1000 bits with frame ends -> a scoreboard matches every symbol, last flag and pad value.
